// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester sequencer sharing one combinational RV32I ALU (IDLE -> EXEC -> RESP).
// Build option: define ALU_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_n,
   input  logic             alu_v,
   input  logic             alu_c,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q,      state_d;
   logic [WIDTH-1:0] alu_a_q,      alu_a_d;
   logic [WIDTH-1:0] alu_b_q,      alu_b_d;
   logic [2:0]       alu_ctrl_q,   alu_ctrl_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q,  rsp_flags_d;
   logic             grant_id_q,   grant_id_d;
`ifdef ALU_ARB_RR_EN
   logic             last_grant_q, last_grant_d;
`endif

   logic gnt0;
   logic gnt1;
   logic rsp_done;

   // Grant is only offered in IDLE and never while reset is held.
   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE && rst) begin
`ifdef ALU_ARB_RR_EN
         gnt0 = req0_valid && (!req1_valid ||  last_grant_q);
         gnt1 = req1_valid && (!req0_valid || !last_grant_q);
`else
         gnt0 = req0_valid;
         gnt1 = req1_valid && !req0_valid;
`endif
      end
   end

   assign rsp_done = grant_id_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      grant_id_d   = grant_id_q;
`ifdef ALU_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt0 || gnt1) begin
               alu_a_d    = gnt1 ? req1_a  : req0_a;
               alu_b_d    = gnt1 ? req1_b  : req0_b;
               alu_ctrl_d = gnt1 ? req1_op : req0_op;
               grant_id_d = gnt1;
`ifdef ALU_ARB_RR_EN
               last_grant_d = gnt1;
`endif
               state_d    = EXEC;
            end
         end
         EXEC: begin
            // ALU inputs have been stable all cycle; flags are passed through untouched.
            rsp_result_d = alu_result;
            rsp_flags_d  = {alu_n, alu_zero, alu_c, alu_v};
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, and every flop has a reset value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= 3'b000;
         rsp_result_q <= '0;
         rsp_flags_q  <= 4'b0000;
         grant_id_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         grant_id_q   <= grant_id_d;
`ifdef ALU_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp0_valid = (state_q == RESP) && !grant_id_q;
   assign rsp1_valid = (state_q == RESP) &&  grant_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign busy       = (state_q != IDLE);

`ifndef SYNTHESIS
   a_ready_excl: assert property (@(posedge clk) disable iff (!rst) !(req0_ready && req1_ready));
   a_rsp_excl:   assert property (@(posedge clk) disable iff (!rst) !(rsp0_valid && rsp1_valid));
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU, scoreboard of expected responses, directed scenarios.
// Expected grant order follows ALU_ARB_RR_EN when it is defined.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result, alu_a, alu_b, alu_result;
   logic [3:0]  rsp_flags;
   logic [2:0]  alu_ctrl;
   logic        alu_zero, alu_n, alu_v, alu_c, busy;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic [3:0]  flags;
   } exp_t;

   exp_t  exp_q[$];
   int    gnt_q[$];
   int    gnt_cyc_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   exp_t  mon_e;
   logic [35:0] mon_m;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
      .busy(busy)
   );

   // Returns {N, Z, C, V, result}; C on subtract is the carry out of a + ~b + 1.
   function automatic logic [35:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'b001: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'b010: r = a & b;
         3'b011: r = a | b;
         3'b101: r = {31'd0, ($signed(a) < $signed(b))};
         default: r = '0;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   always_comb {alu_n, alu_zero, alu_c, alu_v, alu_result} = alu_model(alu_ctrl, alu_a, alu_b);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: push on request handshake, pop on response handshake.
   always @(negedge clk) begin
      if (rst) begin
         cyc++;
         if (req0_valid && req0_ready) begin
            mon_m = alu_model(req0_op, req0_a, req0_b);
            mon_e.id = 1'b0; mon_e.res = mon_m[31:0]; mon_e.flags = mon_m[35:32];
            exp_q.push_back(mon_e); gnt_q.push_back(0); gnt_cyc_q.push_back(cyc);
         end
         if (req1_valid && req1_ready) begin
            mon_m = alu_model(req1_op, req1_a, req1_b);
            mon_e.id = 1'b1; mon_e.res = mon_m[31:0]; mon_e.flags = mon_m[35:32];
            exp_q.push_back(mon_e); gnt_q.push_back(1); gnt_cyc_q.push_back(cyc);
         end
         if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_id", rsp1_valid, mon_e.id);
               check("sb_result", rsp_result, mon_e.res);
               check("sb_flags", rsp_flags, mon_e.flags);
            end
         end
      end
   end

   task automatic drive_point();
      @(posedge clk); #2;
   endtask

   task automatic clear_sb();
      exp_q.delete(); gnt_q.delete(); gnt_cyc_q.delete();
   endtask

   task automatic run_op(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
      int n;
      if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
      n = 0;
      @(negedge clk);
      while (!(id ? req1_ready : req0_ready) && n < 20) begin n++; @(negedge clk); end
      check("op_ready_latency", n, 0);
      drive_point();
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check("exec_ctrl", alu_ctrl, op);
      check("exec_a", alu_a, a);
      check("exec_b", alu_b, b);
      check("exec_busy", busy, 1);
      check("exec_no_rsp", {rsp1_valid, rsp0_valid}, 0);
      @(negedge clk);
      check("resp_valid", {rsp1_valid, rsp0_valid}, id ? 2'b10 : 2'b01);
      check("resp_result", rsp_result, exp_res);
      check("resp_flags", rsp_flags, exp_flags);
      drive_point();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      check("rst_req0_ready", req0_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_alu", {alu_a, alu_b}, 0);
      check("rst_ctrl", alu_ctrl, 0);
      check("rst_rsp", {rsp_result, rsp_flags, rsp1_valid, rsp0_valid}, 0);
      req0_valid = 1'b0;
      repeat (2) drive_point();
      rst = 1'b1;
      drive_point();

      run_op(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 4'b0000);
      run_op(1'b1, 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000);
      run_op(1'b1, 3'b001, 32'd5, 32'd3, 32'd2, 4'b0010);
      run_op(1'b0, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001);
      run_op(1'b0, 3'b010, 32'hF0, 32'h0F, 32'd0, 4'b0100);
      run_op(1'b0, 3'b101, 32'd1, 32'd2, 32'd1, 4'b0000);
      run_op(1'b1, 3'b011, 32'hA0, 32'h05, 32'hA5, 4'b0000);

      // Back-pressure: response held, requester 1 waiting must not be granted.
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd9; req0_b = 32'd4;
      @(negedge clk);
      drive_point();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd1; req1_b = 32'd1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", rsp0_valid, 1);
         check("hold_result", rsp_result, 32'd13);
         check("hold_flags", rsp_flags, 4'b0000);
         check("hold_ready_low", {req1_ready, req0_ready}, 0);
         check("hold_busy", busy, 1);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      @(negedge clk);
      check("hold_release_idle", busy, 0);
      check("hold_release_req1", req1_ready, 1);
      drive_point();
      req1_valid = 1'b0;
      repeat (3) drive_point();

      // Contention from a fresh reset: pointer starts at 1, so requester 0 wins first.
      rst = 1'b0;
      clear_sb();
      drive_point();
      rst = 1'b1;
      drive_point();
      req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1;    req0_b = 32'd2;
      req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'hF0;   req1_b = 32'h0F;
      repeat (12) @(posedge clk);
      #2;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (4) drive_point();
      check("cont_grants", gnt_q.size(), 4);
      for (int i = 0; i < 4 && i < gnt_q.size(); i++) begin
`ifdef ALU_ARB_RR_EN
         check("cont_gnt_id", gnt_q[i], i % 2);
`else
         check("cont_gnt_id", gnt_q[i], 0);
`endif
         if (i > 0) check("cont_spacing", gnt_cyc_q[i] - gnt_cyc_q[i-1], 3);
      end

      // Reset during EXEC aborts the operation with no response.
      req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd10; req1_b = 32'd4;
      n = 0;
      @(negedge clk);
      while (!req1_ready && n < 20) begin n++; @(negedge clk); end
      check("abort_accept", req1_ready, 1);
      drive_point();
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      check("abort_in_exec", busy, 1);
      rst = 1'b0;
      clear_sb();
      #1;
      check("abort_busy", busy, 0);
      check("abort_alu", {alu_a, alu_b, alu_ctrl}, 0);
      check("abort_rsp", {rsp_result, rsp_flags}, 0);
      check("abort_ready", {req1_ready, req0_ready}, 0);
      repeat (2) begin
         @(negedge clk);
         check("abort_no_rsp", {rsp1_valid, rsp0_valid}, 0);
      end
      req0_valid = 1'b0;
      drive_point();
      rst = 1'b1;
      drive_point();
      run_op(1'b1, 3'b001, 32'd10, 32'd4, 32'd6, 4'b0010);
      run_op(1'b0, 3'b111, 32'd3, 32'd3, 32'd0, 4'b0100);
      repeat (2) drive_point();

      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
